// File: rtl/rns_fwd_conv_9_8_7.sv
// rns_fwd_conv_9_8_7: two-stage binary-to-RNS {9,8,7} converter with valid/ready flow control.
// Optional range flagging and saturating error counter enabled by defining RNS_RANGE_CHECK_EN.
module rns_fwd_conv_9_8_7 #(
    parameter int TAG_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [8:0]           x_in,
    input  logic [8:0]           y_in,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic                 in_valid_in,
    output logic                 in_ready_out,
    output logic [3:0]           a1_out,
    output logic [2:0]           a2_out,
    output logic [2:0]           a3_out,
    output logic [3:0]           b1_out,
    output logic [2:0]           b2_out,
    output logic [2:0]           b3_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 out_valid_out,
    input  logic                 out_ready_in,
    output logic                 err_out,
    output logic [ERR_CNT_W-1:0] err_cnt_out
);
    // 64 = 1 (mod 7) and 8 = 1 (mod 7): octal digits simply add
    function automatic logic [4:0] fold7(input logic [8:0] v);
        return {2'b0, v[8:6]} + {2'b0, v[5:3]} + {2'b0, v[2:0]};
    endfunction
    // 64 = 1 (mod 9) and 8 = -1 (mod 9): octal digits alternate in sign
    function automatic logic signed [4:0] fold9(input logic [8:0] v);
        return $signed({2'b0, v[8:6]}) - $signed({2'b0, v[5:3]}) + $signed({2'b0, v[2:0]});
    endfunction
    // second fold leaves 0..8, so one conditional subtract of 7 finishes the job
    function automatic logic [2:0] red7(input logic [4:0] p);
        logic [3:0] q;
        q = {2'b0, p[4:3]} + {1'b0, p[2:0]};
        return (q >= 4'd7) ? 3'(q - 4'd7) : q[2:0];
    endfunction
    function automatic logic [3:0] red9(input logic signed [4:0] p);
        return (p < 0) ? 4'(p + 5'sd9) : (p >= 5'sd9) ? 4'(p - 5'sd9) : p[3:0];
    endfunction
    logic                    s1_valid_q, out_valid_q, s1_adv, s2_adv;
    logic [2:0]              x8_q, y8_q;
    logic [4:0]              x7_q, y7_q;
    logic signed [4:0]       x9_q, y9_q;
    logic [TAG_W-1:0]        tag1_q, tag2_q;
    logic [3:0]              a1_d, b1_d, a1_q, b1_q;
    logic [2:0]              a3_d, b3_d, a2_q, a3_q, b2_q, b3_q;
    assign s2_adv       = !out_valid_q || out_ready_in;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign in_ready_out = s1_adv;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            x8_q <= '0; y8_q <= '0; x7_q <= '0; y7_q <= '0;
            x9_q <= '0; y9_q <= '0; tag1_q <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid_in;
            if (s1_adv && in_valid_in) begin
                x8_q   <= x_in[2:0];
                y8_q   <= y_in[2:0];
                x7_q   <= fold7(x_in);
                y7_q   <= fold7(y_in);
                x9_q   <= fold9(x_in);
                y9_q   <= fold9(y_in);
                tag1_q <= tag_in;
            end
        end
    end
    always_comb begin
        a1_d = red9(x9_q);
        b1_d = red9(y9_q);
        a3_d = red7(x7_q);
        b3_d = red7(y7_q);
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_q <= 1'b0;
            a1_q <= '0; a2_q <= '0; a3_q <= '0;
            b1_q <= '0; b2_q <= '0; b3_q <= '0; tag2_q <= '0;
        end else begin
            if (s2_adv) out_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                a1_q   <= a1_d;
                a2_q   <= x8_q;
                a3_q   <= a3_d;
                b1_q   <= b1_d;
                b2_q   <= y8_q;
                b3_q   <= b3_d;
                tag2_q <= tag1_q;
            end
        end
    end
    assign out_valid_out = out_valid_q;
    assign a1_out  = a1_q;
    assign a2_out  = a2_q;
    assign a3_out  = a3_q;
    assign b1_out  = b1_q;
    assign b2_out  = b2_q;
    assign b3_out  = b3_q;
    assign tag_out = tag2_q;
`ifdef RNS_RANGE_CHECK_EN
    logic                 err1_q, err2_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (s1_adv && in_valid_in) err1_q <= (x_in >= 9'd504) || (y_in >= 9'd504);
            if (s2_adv && s1_valid_q) err2_q <= err1_q;
            if (out_valid_q && out_ready_in && err2_q && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign err_out     = err2_q;
    assign err_cnt_out = cnt_q;
`else
    assign err_out     = 1'b0;
    assign err_cnt_out = '0;
`endif
endmodule

// File: tb/tb_rns_fwd_conv_9_8_7.sv
// tb_rns_fwd_conv_9_8_7: scoreboard bench for the {9,8,7} forward converter.
module tb_rns_fwd_conv_9_8_7;
    localparam int TAG_W = 4;
    localparam int ERR_CNT_W = 8;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [8:0] x = 0, y = 0;
    logic [TAG_W-1:0] tag = 0;
    logic in_ready, out_valid, err;
    logic [3:0] a1, b1;
    logic [2:0] a2, a3, b2, b3;
    logic [TAG_W-1:0] tag_o;
    logic [ERR_CNT_W-1:0] err_cnt;
    typedef struct packed {
        logic [3:0] a1; logic [2:0] a2, a3;
        logic [3:0] b1; logic [2:0] b2, b3;
        logic [TAG_W-1:0] tag; logic err;
    } exp_t;
    exp_t exp_q[$];
    int out_cyc[$];
    int checks = 0, errors = 0, cyc = 0, cnt_model = 0;
    int ready_mode = 0;
    logic ready_val = 1;
    logic prev_stall = 0;
    logic [TAG_W+24:0] prev_out;

    rns_fwd_conv_9_8_7 #(.TAG_W(TAG_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .x_in(x), .y_in(y), .tag_in(tag),
        .in_valid_in(in_valid), .in_ready_out(in_ready),
        .a1_out(a1), .a2_out(a2), .a3_out(a3), .b1_out(b1), .b2_out(b2), .b3_out(b3),
        .tag_out(tag_o), .out_valid_out(out_valid), .out_ready_in(out_ready),
        .err_out(err), .err_cnt_out(err_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        out_ready = ready_mode != 0 ? ($urandom_range(0, 2) != 0) : ready_val;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // residues straight from integer arithmetic
    function automatic exp_t model(input int vx, input int vy, input int t);
        exp_t e;
        e.a1 = 4'(vx % 9); e.a2 = 3'(vx % 8); e.a3 = 3'(vx % 7);
        e.b1 = 4'(vy % 9); e.b2 = 3'(vy % 8); e.b3 = 3'(vy % 7);
        e.tag = TAG_W'(t);
`ifdef RNS_RANGE_CHECK_EN
        e.err = (vx >= 504) || (vy >= 504);
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk)
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(int'(x), int'(y), int'(tag)));

    always @(negedge clk) begin
        logic [TAG_W+24:0] cur;
        exp_t e;
        cur = {out_valid, a1, a2, a3, b1, b2, b3, tag_o, err, err_cnt};
        if (rst_n) begin
            if (prev_stall) check("hold", cur, prev_out);
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got a1=%0d tag=%0d expected no output", a1, tag_o);
                end else begin
                    e = exp_q.pop_front();
                    check("a1", a1, e.a1); check("a2", a2, e.a2); check("a3", a3, e.a3);
                    check("b1", b1, e.b1); check("b2", b2, e.b2); check("b3", b3, e.b3);
                    check("tag", tag_o, e.tag); check("err", err, e.err);
                    check("err_cnt", err_cnt, cnt_model);
                    if (e.err && cnt_model < 255) cnt_model++;
                end
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_out = cur;
    end

    task automatic send(input int vx, input int vy, input int t);
        bit ok = 0;
        in_valid = 1; x = 9'(vx); y = 9'(vy); tag = TAG_W'(t);
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 2000 cycles");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_in_valid_out", out_valid, 0);
        check("rst_a1", a1, 0);
        check("rst_tag", tag_o, 0);
        check("rst_err_cnt", err_cnt, 0);
        idle(2);
        rst_n = 1;
        idle(1);
        check("post_rst_in_ready", in_ready, 1);
        // exact two-cycle latency
        in_valid = 1; x = 503; y = 0; tag = 5;
        @(negedge clk); check("lat_accept", in_ready, 1);
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk); check("lat_cycle1_valid", out_valid, 0);
        @(negedge clk); check("lat_cycle2_valid", out_valid, 1);
        check("lat_a1", a1, 8); check("lat_a3", a3, 6); check("lat_tag", tag_o, 5);
        idle(3);
        // back-to-back stream emerges on consecutive cycles
        out_cyc.delete();
        send(100, 0, 1); send(255, 0, 2); send(7, 0, 3); send(9, 0, 4);
        idle(5);
        check("stream_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("stream_consecutive", out_cyc[i] - out_cyc[i-1], 1);
        // stall with three pairs offered
        ready_val = 0;
        idle(2);
        fork
            begin send(11, 22, 6); send(33, 44, 7); send(55, 66, 8); end
            begin
                repeat (5) @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_queue", exp_q.size(), 2);
                ready_val = 1;
            end
        join
        idle(5);
        check("stall_drained", exp_q.size(), 0);
        // range-boundary pairs
        send(510, 3, 9); send(10, 0, 10); send(504, 503, 11); send(511, 511, 12);
        idle(5);
        // reset with two pairs in flight
        ready_val = 0;
        idle(2);
        send(1, 2, 13); send(3, 4, 14);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_a1", a1, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        exp_q.delete();
        cnt_model = 0;
        idle(2);
        rst_n = 1;
        ready_val = 1;
        out_cyc.delete();
        idle(6);
        check("post_rst_silent", out_cyc.size(), 0);
        // full sweep of 9-bit values, then randomized traffic under random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 512; i++) send(i, 511 - i, i);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 15));
        end
        ready_mode = 0;
        ready_val = 1;
        idle(10);
        check("final_drained", exp_q.size(), 0);
        check("final_err_cnt", err_cnt, cnt_model);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
